counter_sequencer: RTL and testbench

//  Control unit plus datapath for a prescaled binary counter. An FSM gates a

---
 rtl/counter_sequencer.sv | 128 ++++++++++++
 tb/tb_counter_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - FSM-sequenced prescaled counter with wrap/one-shot modes and pause/resume/abort.
// Optional gate input enabled by defining CNT_SEQ_GATE_EN.
module counter_sequencer #(
    parameter int SIZE  = 4,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic [SIZE-1:0]  limit,
`ifdef CNT_SEQ_GATE_EN
    input  logic             gate,
`endif
    output logic [SIZE-1:0]  count,
    output logic             tick,
    output logic             busy,
    output logic             wrap,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [SIZE-1:0]  CNT_ONE = {{(SIZE-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [SIZE-1:0]  count_q, count_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [SIZE-1:0]  lim_q, lim_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             gate_ok;
    logic             at_lim;

`ifdef CNT_SEQ_GATE_EN
    assign gate_ok = gate;
`else
    assign gate_ok = 1'b1;
`endif

    // stop pre-empts a tick in the same cycle, so tick depends on it combinationally
    assign at_lim = (count_q == lim_q);
    assign tick   = (state_q == RUN) && !stop && gate_ok && (presc_q == div_q - DIV_ONE);
    assign wrap   = tick && at_lim && !mode_q;
    assign busy   = (state_q == RUN) || (state_q == PAUSE);
    assign count  = count_q;
    assign done   = done_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        div_d   = div_q;
        lim_d   = lim_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start && !stop) begin
                    div_d   = (div_ratio == '0) ? DIV_ONE : div_ratio;
                    lim_d   = limit;
                    mode_d  = oneshot;
                    count_d = '0;
                    presc_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = PAUSE;
                end else if (!gate_ok) begin
                    presc_d = '0;
                end else if (tick) begin
                    presc_d = '0;
                    if (!at_lim) begin
                        count_d = count_q + CNT_ONE;
                    end else if (mode_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        count_d = '0;
                    end
                end else begin
                    presc_d = presc_q + DIV_ONE;
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                    presc_d = '0;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            presc_q <= '0;
            div_q   <= DIV_ONE;
            lim_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            div_q   <= div_d;
            lim_q   <= lim_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - table-driven self-checking bench for counter_sequencer.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, stop, oneshot;
    logic [3:0] div_ratio, limit;
    logic [3:0] count;
    logic       tick, busy, wrap, done;
`ifdef CNT_SEQ_GATE_EN
    logic       gate;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    counter_sequencer #(.SIZE(4), .DIV_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .oneshot(oneshot),
        .div_ratio(div_ratio), .limit(limit),
`ifdef CNT_SEQ_GATE_EN
        .gate(gate),
`endif
        .count(count), .tick(tick), .busy(busy), .wrap(wrap), .done(done)
    );

    typedef struct {
        logic       rst, start, stop, oneshot;
        logic [3:0] div, lim;
        logic [3:0] e_count;
        logic       e_tick, e_busy, e_wrap, e_done;
    } vec_t;

    vec_t vt[$];

    task automatic v(input logic r, st, sp, os, input logic [3:0] dv, lm,
                     input logic [3:0] ec, input logic et, eb, ew, ed);
        vec_t x;
        x.rst = r; x.start = st; x.stop = sp; x.oneshot = os; x.div = dv; x.lim = lm;
        x.e_count = ec; x.e_tick = et; x.e_busy = eb; x.e_wrap = ew; x.e_done = ed;
        vt.push_back(x);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: {count,tick,busy,wrap,done} got %h/%b%b%b%b want %h/%b%b%b%b",
                     name, act[7:4], act[3], act[2], act[1], act[0],
                     exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [7:0] outs();
        return {count, tick, busy, wrap, done};
    endfunction

    initial begin
        int n;
        // T2: div 3, limit 4, wrap mode
        v(0,1,0,0,3,4, 0,0,0,0,0);
        v(0,0,0,0,3,4, 0,0,1,0,0); v(0,0,0,0,3,4, 0,0,1,0,0); v(0,0,0,0,3,4, 0,1,1,0,0);
        v(0,0,0,0,3,4, 1,0,1,0,0); v(0,0,0,0,3,4, 1,0,1,0,0); v(0,0,0,0,3,4, 1,1,1,0,0);
        v(0,0,0,0,3,4, 2,0,1,0,0); v(0,0,0,0,3,4, 2,0,1,0,0); v(0,0,0,0,3,4, 2,1,1,0,0);
        v(0,0,0,0,3,4, 3,0,1,0,0); v(0,0,0,0,3,4, 3,0,1,0,0); v(0,0,0,0,3,4, 3,1,1,0,0);
        v(0,0,0,0,3,4, 4,0,1,0,0); v(0,0,0,0,3,4, 4,0,1,0,0); v(0,0,0,0,3,4, 4,1,1,1,0);
        v(0,0,1,0,3,4, 0,0,1,0,0); v(0,0,1,0,3,4, 0,0,1,0,0); v(0,0,0,0,3,4, 0,0,0,0,0);
        // T3: div 1, limit 2, one-shot
        v(0,1,0,1,1,2, 0,0,0,0,0);
        v(0,0,0,0,1,2, 0,1,1,0,0); v(0,0,0,0,1,2, 1,1,1,0,0); v(0,0,0,0,1,2, 2,1,1,0,0);
        v(0,0,0,0,1,2, 2,0,0,0,1); v(0,0,0,0,1,2, 2,0,0,0,0);
        // T4: div 4, pause in RUN cycle 2, resume after 5 cycles
        v(0,1,0,0,4,9, 2,0,0,0,0);
        v(0,0,0,0,4,9, 0,0,1,0,0); v(0,0,0,0,4,9, 0,0,1,0,0); v(0,0,1,0,4,9, 0,0,1,0,0);
        for (int i = 0; i < 5; i++) v(0,0,0,0,1,1, 0,0,1,0,0);
        v(0,1,0,0,1,1, 0,0,1,0,0);
        v(0,0,0,0,1,1, 0,0,1,0,0); v(0,0,0,0,1,1, 0,1,1,0,0); v(0,0,0,0,1,1, 1,0,1,0,0);
        v(0,0,0,0,1,1, 1,0,1,0,0); v(0,0,0,0,1,1, 1,0,1,0,0);
        // T5: start+stop on a tick cycle pauses and pre-empts; abort keeps count
        v(0,1,1,0,1,1, 1,0,1,0,0); v(0,0,1,0,1,1, 1,0,1,0,0); v(0,0,0,0,1,1, 1,0,0,0,0);
        v(0,1,1,0,1,1, 1,0,0,0,0); v(0,0,0,0,1,1, 1,0,0,0,0);
        // div 0 ticks every cycle; limit 0 wraps every tick
        v(0,1,0,0,0,3, 1,0,0,0,0);
        v(0,0,0,0,0,3, 0,1,1,0,0); v(0,0,0,0,0,3, 1,1,1,0,0); v(0,0,0,0,0,3, 2,1,1,0,0);
        v(0,0,0,0,0,3, 3,1,1,1,0); v(0,0,0,0,0,3, 0,1,1,0,0);
        v(0,0,1,0,0,3, 1,0,1,0,0); v(0,0,1,0,0,3, 1,0,1,0,0);
        v(0,1,0,0,0,0, 1,0,0,0,0);
        v(0,0,0,0,0,0, 0,1,1,1,0); v(0,0,0,0,0,0, 0,1,1,1,0); v(0,0,0,0,0,0, 0,1,1,1,0);
        v(0,0,1,0,0,0, 0,0,1,0,0); v(0,0,1,0,0,0, 0,0,1,0,0);
        // T1: reset mid-RUN at count 5, with start held high
        v(0,1,0,0,1,9, 0,0,0,0,0);
        v(0,0,0,0,1,9, 0,1,1,0,0); v(0,0,0,0,1,9, 1,1,1,0,0); v(0,0,0,0,1,9, 2,1,1,0,0);
        v(0,0,0,0,1,9, 3,1,1,0,0); v(0,0,0,0,1,9, 4,1,1,0,0);
        v(1,1,0,0,1,9, 5,1,1,0,0); v(0,0,0,0,1,9, 0,0,0,0,0); v(0,0,0,0,1,9, 0,0,0,0,0);

        rst = 1'b1; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
        div_ratio = 4'd0; limit = 4'd0;
`ifdef CNT_SEQ_GATE_EN
        gate = 1'b1;
`endif
        @(negedge clk); @(negedge clk);
        #1 check("reset_state", outs(), 8'h00);

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            rst = vt[i].rst; start = vt[i].start; stop = vt[i].stop;
            oneshot = vt[i].oneshot; div_ratio = vt[i].div; limit = vt[i].lim;
            #1 check($sformatf("vec%0d", i), outs(),
                     {vt[i].e_count, vt[i].e_tick, vt[i].e_busy, vt[i].e_wrap, vt[i].e_done});
        end

        // one-shot div 2, limit 3: done expected 8 cycles after the start edge
        @(negedge clk);
        start = 1'b1; oneshot = 1'b1; div_ratio = 4'd2; limit = 4'd3;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        #1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            #1;
        end
        check("oneshot_done_latency", {4'(n), 4'b0}, {4'd8, 4'b0});
        check("oneshot_done_cycle", outs(), {4'd3, 1'b0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        #1 check("oneshot_done_pulse_end", outs(), {4'd3, 4'b0000});

`ifdef CNT_SEQ_GATE_EN
        // T6: gate pattern 1,1,0,1,1,1 with div 3 gives exactly one tick in the 6th cycle
        begin
            logic [5:0] gpat;
            logic [5:0] tpat;
            gpat = 6'b111011;
            tpat = 6'b100000;
            @(negedge clk);
            start = 1'b1; oneshot = 1'b0; div_ratio = 4'd3; limit = 4'd9; gate = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                start = 1'b0; gate = gpat[i];
                #1 check($sformatf("gate_cyc%0d", i), outs(),
                         {4'd0, tpat[i], 1'b1, 1'b0, 1'b0});
            end
            @(negedge clk);
            gate = 1'b1;
            #1 check("gate_count", {count, 4'b0}, {4'd1, 4'b0});
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
